// File: rtl/sorted_stream_reader.sv
// Captures the sorter's flattened result on the done_in rising edge and replays it
// rank-ordered as a valid/ready stream. Define TOPK_EN to emit only the first TOP_K words.
module sorted_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned IDX_WIDTH  = 5,
  parameter int unsigned TOP_K      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] array_in_flattened,
  input  logic                            done_in,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [IDX_WIDTH-1:0]            out_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            stream_done
);

`ifdef TOPK_EN
  localparam int unsigned BUF_WORDS = TOP_K;
  logic unused_upper_words;
  assign unused_upper_words = ^array_in_flattened[DATA_WIDTH*NUM_WORDS-1:DATA_WIDTH*TOP_K];
`else
  localparam int unsigned BUF_WORDS = NUM_WORDS;
`endif
  localparam int unsigned LAST = BUF_WORDS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state, state_next;
  logic                  done_d;
  logic [DATA_WIDTH-1:0] buffer [BUF_WORDS];
  logic [DATA_WIDTH-1:0] next_word;
  logic [31:0]           next_pos;
  logic                  start;
  logic                  xfer;
  logic                  at_last;

  assign start       = done_in & ~done_d;
  assign xfer        = out_valid & out_ready;
  assign at_last     = (out_index == IDX_WIDTH'(LAST));
  assign out_last    = out_valid & at_last;
  assign busy        = (state == CAPTURE) || (state == STREAM);
  assign stream_done = (state == DONE);
  assign next_pos    = 32'(out_index) + 32'd1;

  // Mux over the buffer instead of direct indexing keeps the index width independent of IDX_WIDTH.
  always_comb begin
    next_word = '0;
    for (int unsigned i = 0; i < BUF_WORDS; i++) begin
      if (i == next_pos) next_word = buffer[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: state_next = STREAM;
      STREAM:  if (xfer && at_last) state_next = DONE;
      DONE:    if (!done_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_d    <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < BUF_WORDS; i++) buffer[i] <= '0;
    end else begin
      done_d <= done_in;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < BUF_WORDS; i++)
              buffer[i] <= array_in_flattened[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        CAPTURE: begin
          out_data  <= buffer[0];
          out_index <= '0;
          out_valid <= 1'b1;
        end
        STREAM: begin
          if (xfer) begin
            if (at_last) begin
              out_valid <= 1'b0;
            end else begin
              out_data  <= next_word;
              out_index <= IDX_WIDTH'(next_pos);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_stream_reader.sv
// Directed bench for sorted_stream_reader: latency, backpressure, capture isolation,
// restart gating and async reset. Expectations follow TOPK_EN when it is defined.
module tb_sorted_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned TK = 2;
`ifdef TOPK_EN
  localparam int FRAME = TK;
`else
  localparam int FRAME = NW;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [DW*NW-1:0] array_in;
  logic            done_in;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            stream_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_w [4] = '{8'h40, 8'h30, 8'h20, 8'h10};

  always #5 clk = ~clk;

  sorted_stream_reader #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW),
    .IDX_WIDTH (IW),
    .TOP_K     (TK)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .array_in_flattened(array_in),
    .done_in           (done_in),
    .out_data          (out_data),
    .out_index         (out_index),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .stream_done       (stream_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    done_in = 1'b1;
    tick();
    check("cap_valid", 32'(out_valid), 0);
    check("cap_busy", 32'(busy), 1);
    tick();
    check("lat_valid", 32'(out_valid), 1);
    check("lat_index", 32'(out_index), 0);
  endtask

  task automatic run_stream(input logic [3:0] pat, input bit corrupt, input int stop_after);
    int k = 0;
    int cyc = 0;
    while (k < stop_after && cyc < 64) begin
      out_ready = pat[cyc % 4];
      if (out_valid) begin
        check("data", 32'(out_data), 32'(exp_w[k]));
        check("index", 32'(out_index), 32'(k));
        check("last", 32'(out_last), (k == FRAME - 1) ? 1 : 0);
        check("busy", 32'(busy), 1);
        if (out_ready) k++;
      end
      if (corrupt && k > 0) array_in = '1;
      tick();
      cyc++;
    end
    check("xfer_count", 32'(k), 32'(stop_after));
  endtask

  task automatic check_done();
    check("end_valid", 32'(out_valid), 0);
    check("end_last", 32'(out_last), 0);
    check("end_sdone", 32'(stream_done), 1);
    check("end_busy", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    done_in   = 1'b0;
    out_ready = 1'b0;
    array_in  = {8'h10, 8'h20, 8'h30, 8'h40};
    #23;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_index", 32'(out_index), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sdone", 32'(stream_done), 0);
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_valid", 32'(out_valid), 0);

    // Frame 1: full throughput
    out_ready = 1'b1;
    start_frame();
    run_stream(4'b1111, 1'b0, FRAME);
    check_done();

    // Done held high: no restart
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_sdone", 32'(stream_done), 1);
      check("hold_valid", 32'(out_valid), 0);
    end

    // One-cycle low pulse; frame 2 with backpressure and input corruption
    done_in = 1'b0;
    tick();
    check("relow_sdone", 32'(stream_done), 0);
    start_frame();
    run_stream(4'b1001, 1'b1, FRAME);
    check_done();
    tick();
    check("hold2_sdone", 32'(stream_done), 1);

    // Frame 3 interrupted by reset
    array_in = {8'h10, 8'h20, 8'h30, 8'h40};
    done_in  = 1'b0;
    tick();
    start_frame();
    run_stream(4'b1111, 1'b0, FRAME / 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(out_data), 0);
    check("arst_index", 32'(out_index), 0);
    check("arst_last", 32'(out_last), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sdone", 32'(stream_done), 0);
    #3;
    reset_n = 1'b1;
    #1;
    start_frame();
    run_stream(4'b1111, 1'b0, FRAME);
    check_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
